paddle_logic: RTL and testbench

Player paddle controller for the 8-bit pong design. Takes two raw push-button inputs, synchronises and debounces them, and moves a vertical paddle position once per frame on the rising edge of `vsync` from `hvsync_generator`. It sits beside the ball logic, upstream of the pixel mux in the pong top level. It also produces a `paddle_on` pixel flag from the raster position, which the top level ORs into its WHITE selection.

---
 rtl/paddle_logic_pkg.sv | 31 +++
 rtl/paddle_logic_button_debounce.sv | 38 +++
 rtl/paddle_logic.sv | 96 +++++++++
 tb/tb_paddle_logic.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_logic_pkg.sv
// Shared pong geometry and paddle types used by the paddle controller and the pong top level.
package paddle_logic_pkg;

  localparam int POS_W = 9;

  localparam int DEF_DISPLAY_WIDTH  = 256;
  localparam int DEF_DISPLAY_HEIGHT = 240;
  localparam int DEF_PADDLE_HPOS    = 8;
  localparam int DEF_PADDLE_WIDTH   = 4;
  localparam int DEF_PADDLE_HEIGHT  = 32;
  localparam int DEF_PADDLE_SPEED   = 2;
  localparam int DEF_DEBOUNCE_BITS  = 16;

  typedef logic [POS_W-1:0] pos_t;
  // One spare bit so the down-move sum can exceed the clamp without wrapping.
  typedef logic [POS_W:0]   pos_ext_t;

  typedef enum logic [1:0] {
    MOVE_HOLD,
    MOVE_UP,
    MOVE_DOWN
  } move_t;

  // Pressing both buttons cancels out, as does pressing neither.
  function automatic move_t decode_move(input logic up, input logic down);
    if (up && !down)      return MOVE_UP;
    else if (down && !up) return MOVE_DOWN;
    else                  return MOVE_HOLD;
  endfunction

endpackage

// File: rtl/paddle_logic_button_debounce.sv
// Two-flop synchroniser plus counter debounce for one raw, bouncy push button.
module button_debounce
  import paddle_logic_pkg::*;
#(
  parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_stable
);

  localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = DEBOUNCE_BITS'(1);

  logic [1:0]               sync_q;
  logic [DEBOUNCE_BITS-1:0] cnt;

  // NOTE: all state here is flops updated with non-blocking assignments, so every
  // reader sees the pre-edge value and the synchroniser really is two stages deep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      cnt        <= '0;
      btn_stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      if (sync_q[1] == btn_stable) begin
        cnt <= '0;
      end else if (&cnt) begin
        btn_stable <= ~btn_stable;
        cnt        <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/paddle_logic.sv
// Player paddle: debounced up/down buttons move the paddle once per frame; paddle_on marks its pixels.
module paddle_logic
  import paddle_logic_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
  parameter int PADDLE_HPOS    = DEF_PADDLE_HPOS,
  parameter int PADDLE_WIDTH   = DEF_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT  = DEF_PADDLE_HEIGHT,
  parameter int PADDLE_SPEED   = DEF_PADDLE_SPEED,
  parameter int DEBOUNCE_BITS  = DEF_DEBOUNCE_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic [POS_W-1:0] hpos,
  input  logic [POS_W-1:0] vpos,
  input  logic             display_on,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [POS_W-1:0] paddle_vpos,
  output logic             paddle_on
);

  localparam int       MAX_VPOS   = DISPLAY_HEIGHT - PADDLE_HEIGHT;
  localparam pos_ext_t MAX_EXT    = pos_ext_t'(MAX_VPOS);
  localparam pos_ext_t SPEED_EXT  = pos_ext_t'(PADDLE_SPEED);
  localparam pos_t     RESET_VPOS = pos_t'(MAX_VPOS / 2);

  if (MAX_VPOS <= 0 || MAX_VPOS >= 2**POS_W ||
      PADDLE_HPOS + PADDLE_WIDTH > DISPLAY_WIDTH) begin : g_bad_geometry
    $error("paddle_logic: paddle does not fit on the display");
  end

  logic  st_up;
  logic  st_down;
  logic  vsync_q;
  logic  tick;
  move_t move;

  button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_up (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_up),
    .btn_stable (st_up)
  );

  button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_down (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_down),
    .btn_stable (st_down)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vsync_q <= 1'b0;
    else        vsync_q <= vsync;
  end

  assign tick = vsync & ~vsync_q;
  assign move = decode_move(st_up, st_down);

  pos_ext_t vpos_ext;
  pos_ext_t down_sum;
  pos_t     vpos_next;

  assign vpos_ext = {1'b0, paddle_vpos};
  assign down_sum = vpos_ext + SPEED_EXT;

  // NOTE: vpos_next gets its hold value first, so no path through this block
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    vpos_next = paddle_vpos;
    if (tick) begin
      case (move)
        MOVE_UP:   vpos_next = (vpos_ext >= SPEED_EXT) ? pos_t'(vpos_ext - SPEED_EXT) : '0;
        MOVE_DOWN: vpos_next = (down_sum <= MAX_EXT) ? down_sum[POS_W-1:0] : MAX_EXT[POS_W-1:0];
        default:   vpos_next = paddle_vpos;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) paddle_vpos <= RESET_VPOS;
    else        paddle_vpos <= vpos_next;
  end

  // Modulo-512 differences: anything left of / above the paddle wraps large and fails the compare.
  pos_t hdiff;
  pos_t vdiff;

  assign hdiff     = hpos - pos_t'(PADDLE_HPOS);
  assign vdiff     = vpos - paddle_vpos;
  assign paddle_on = display_on && (hdiff < pos_t'(PADDLE_WIDTH)) && (vdiff < pos_t'(PADDLE_HEIGHT));

endmodule

// File: tb/tb_paddle_logic.sv
// Directed plus random bench for paddle_logic, checked against a frame/sample-history reference model.
module tb_paddle_logic;

  localparam int DB_BITS = 4;
  localparam int DB_LEN  = 16;
  localparam int MAXV    = 208;
  localparam int START_V = 104;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       display_on = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [8:0] hpos = '0;
  logic [8:0] vpos = '0;
  logic [8:0] pv2, pv3;
  logic       on2, on3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  paddle_logic #(.DEBOUNCE_BITS(DB_BITS)) dut2 (
    .clk(clk), .reset(reset), .vsync(vsync), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .btn_up(btn_up), .btn_down(btn_down),
    .paddle_vpos(pv2), .paddle_on(on2)
  );

  paddle_logic #(.DEBOUNCE_BITS(DB_BITS), .PADDLE_SPEED(3)) dut3 (
    .clk(clk), .reset(reset), .vsync(vsync), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .btn_up(btn_up), .btn_down(btn_down),
    .paddle_vpos(pv3), .paddle_on(on3)
  );

  // Reference model: raw button history per edge; a synced sample is the raw value two edges back.
  bit hist_up[$];
  bit hist_dn[$];
  bit m_st_up, m_st_dn, m_vq;
  int m_pv[2];

  function automatic bit flip_due(input bit q[$], input bit st);
    if (q.size() < DB_LEN + 2) return 1'b0;
    for (int j = 0; j < DB_LEN; j++)
      if (q[q.size() - 3 - j] == st) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int moved(input int pv, input int sp);
    if (m_st_up && !m_st_dn) return (pv - sp < 0) ? 0 : pv - sp;
    if (m_st_dn && !m_st_up) return (pv + sp > MAXV) ? MAXV : pv + sp;
    return pv;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_up.delete();
      hist_dn.delete();
      m_st_up = 1'b0;
      m_st_dn = 1'b0;
      m_vq    = 1'b0;
      m_pv[0] = START_V;
      m_pv[1] = START_V;
    end else begin
      if (vsync && !m_vq) begin
        m_pv[0] = moved(m_pv[0], 2);
        m_pv[1] = moved(m_pv[1], 3);
      end
      m_vq = vsync;
      hist_up.push_back(btn_up);
      hist_dn.push_back(btn_down);
      if (flip_due(hist_up, m_st_up)) m_st_up = !m_st_up;
      if (flip_due(hist_dn, m_st_dn)) m_st_dn = !m_st_dn;
      if (hist_up.size() > 40) void'(hist_up.pop_front());
      if (hist_dn.size() > 40) void'(hist_dn.pop_front());
    end
  end

  function automatic bit exp_on(input int pv);
    return display_on && hpos >= 8 && hpos <= 11 && int'(vpos) >= pv && int'(vpos) < pv + 32;
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("model_pv2", pv2, 10'(m_pv[0]));
      chk("model_pv3", pv3, 10'(m_pv[1]));
      chk("model_on2", on2, 10'(exp_on(m_pv[0])));
      chk("model_on3", on3, 10'(exp_on(m_pv[1])));
    end
  endtask

  // One frame; the new position must already show one cycle after vsync rises.
  task automatic frame_chk(input string tag, input int e2, input int e3);
    vsync = 1'b1;
    cyc(1);
    chk({tag, "_pv2"}, pv2, 10'(e2));
    chk({tag, "_pv3"}, pv3, 10'(e3));
    cyc(2);
    vsync = 1'b0;
    cyc(22);
  endtask

  initial begin
    int e2, e3, fr, flen;

    #1 reset = 1'b0;
    #1;
    chk("reset_pv", pv2, 10'd104);
    chk("reset_on", on2, 10'd0);
    cyc(3);
    reset = 1'b1;
    cyc(3);
    for (int i = 0; i < 3; i++) frame_chk("idle", 104, 104);

    display_on = 1'b1;
    for (int h = 7; h <= 12; h++) begin
      for (int v = 103; v <= 136; v++) begin
        hpos = 9'(h);
        vpos = 9'(v);
        cyc(1);
        chk("pixel", on2, 10'(h >= 8 && h <= 11 && v >= 104 && v <= 135));
      end
    end
    hpos = 9'd9;
    vpos = 9'd110;
    display_on = 1'b0;
    cyc(1);
    chk("pixel_blank", on2, 10'd0);

    for (int i = 0; i < 40; i++) begin
      btn_down = ~btn_down;
      cyc(5);
    end
    btn_down = 1'b0;
    cyc(20);
    frame_chk("bounce", 104, 104);
    btn_down = 1'b1;
    cyc(20);
    btn_down = 1'b0;
    frame_chk("press20", 106, 107);
    cyc(20);

    btn_up = 1'b1;
    btn_down = 1'b1;
    cyc(20);
    for (int i = 0; i < 5; i++) frame_chk("both", 106, 107);
    btn_up = 1'b0;
    btn_down = 1'b0;
    cyc(20);

    btn_up = 1'b1;
    cyc(8);
    vsync = 1'b1;
    cyc(1);
    reset = 1'b0;
    #1;
    chk("midrst_pv2", pv2, 10'd104);
    chk("midrst_pv3", pv3, 10'd104);
    chk("midrst_on", on2, 10'd0);
    cyc(3);
    vsync = 1'b0;
    reset = 1'b1;
    cyc(5);
    frame_chk("fresh", 104, 104);
    cyc(5);

    for (int i = 1; i <= 70; i++) begin
      e2 = (104 - 2 * i < 0) ? 0 : 104 - 2 * i;
      e3 = (104 - 3 * i < 0) ? 0 : 104 - 3 * i;
      frame_chk("hold_up", e2, e3);
    end
    btn_up = 1'b0;
    cyc(20);

    btn_down = 1'b1;
    cyc(20);
    for (int i = 1; i <= 110; i++) begin
      e2 = (2 * i > MAXV) ? MAXV : 2 * i;
      e3 = (3 * i > MAXV) ? MAXV : 3 * i;
      frame_chk("hold_down", e2, e3);
    end
    btn_down = 1'b0;
    cyc(20);

    fr = 0;
    flen = 25;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 29) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 29) == 0) btn_down = ~btn_down;
      vsync = (fr < 2);
      fr++;
      if (fr >= flen) begin
        fr = 0;
        flen = $urandom_range(20, 45);
      end
      hpos = 9'($urandom_range(0, 15));
      vpos = 9'($urandom_range(0, 300));
      display_on = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) begin
        display_on = 1'b0;
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
      end
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
